// File: rtl/drc_frm_upscaler.sv
// -----------------------------------------------------------------------------
// drc_frm_upscaler
//
// 2x2 nearest-neighbour frame upscaler. Each input pixel (r,c) of a
// COL_NUM/2 x ROW_NUM/2 frame is emitted as output pixels (2r,2c), (2r,2c+1),
// (2r+1,2c) and (2r+1,2c+1) of a COL_NUM x ROW_NUM frame.
//
// Even output rows consume input pixels and store them in a half-row line
// buffer. Odd output rows replay the line buffer without consuming input.
// A single output hold register (data + copy bit) emits every pixel twice.
//
// Ports
//   clk               in   clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   bwd_pxl_data_i    in   input pixel
//   bwd_pxl_last_i    in   last input pixel of frame (used only by the check)
//   bwd_pxl_vld_i     in   input valid
//   bwd_pxl_rdy_o     out  input ready (combinational from fwd_pxl_rdy_i)
//   fwd_pxl_data_o    out  output pixel
//   fwd_pxl_last_o    out  last output pixel of frame (counter derived)
//   fwd_pxl_vld_o     out  output valid
//   fwd_pxl_rdy_i     in   output ready
//   frm_err_o         out  sticky frame-length error (DRC_UPSCALER_CHK_EN only)
//
// Build option
//   DRC_UPSCALER_CHK_EN : adds frm_err_o and the input frame-length check.
//                         Without it bwd_pxl_last_i is ignored.
//
// FSM states
//   state    | meaning
//   ROW_EVEN | consume input, emit twice, store to line buffer
//   ROW_ODD  | replay line buffer, no input consumed
// -----------------------------------------------------------------------------
module drc_frm_upscaler #(
    parameter int I_PXL_W = 8,
    parameter int COL_NUM = 640,
    parameter int ROW_NUM = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [I_PXL_W-1:0] bwd_pxl_data_i,
    input  logic               bwd_pxl_last_i,
    input  logic               bwd_pxl_vld_i,
    output logic               bwd_pxl_rdy_o,
    output logic [I_PXL_W-1:0] fwd_pxl_data_o,
    output logic               fwd_pxl_last_o,
    output logic               fwd_pxl_vld_o,
    input  logic               fwd_pxl_rdy_i
`ifdef DRC_UPSCALER_CHK_EN
    ,
    output logic               frm_err_o
`endif
);

    localparam int IC  = COL_NUM / 2;
    localparam int IR  = ROW_NUM / 2;
    localparam int CW  = (IC > 1) ? $clog2(IC) : 1;
    localparam int RW  = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IC - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW_NUM - 1);

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [I_PXL_W-1:0] lbuf [IC];

    logic               hold_vld_q;
    logic               copy_q;
    logic [I_PXL_W-1:0] hold_data_q;
    logic [CW-1:0]      col_q;       // next column to load (input or replay)
    logic [CW-1:0]      out_col_q;   // column of the pixel held for output
    logic [RW-1:0]      out_row_q;

    logic               fwd_hs;
    logic               refill_ok;
    logic               load;
    logic               load_even;
    logic [I_PXL_W-1:0] load_data;
    logic               col_wrap;

    assign fwd_hs    = hold_vld_q & fwd_pxl_rdy_i;
    // Hold can take a new pixel when empty, or when its second replica
    // leaves this very cycle; this keeps the output gap-free.
    assign refill_ok = ~hold_vld_q | (copy_q & fwd_hs);
    assign col_wrap  = (col_q == COL_LAST);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ROW_EVEN;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        if (load && col_wrap) begin
            state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
        end
    end

    // --------------------------------------------------------------- output
    always_comb begin
        bwd_pxl_rdy_o = 1'b0;
        load_even     = 1'b0;
        load          = 1'b0;
        load_data     = lbuf[col_q];
        case (state_q)
            ROW_EVEN: begin
                bwd_pxl_rdy_o = refill_ok;
                load_even     = bwd_pxl_vld_i & refill_ok;
                load          = load_even;
                load_data     = bwd_pxl_data_i;
            end
            ROW_ODD: begin
                load = refill_ok;
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------- line buffer
    // The odd-row replay finishes loading its last column before the FSM
    // returns to ROW_EVEN, so next-row writes never clobber pending data.
    always_ff @(posedge clk) begin
        if (load_even) begin
            lbuf[col_q] <= bwd_pxl_data_i;
        end
    end

    // ------------------------------------------------------ hold + counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q  <= 1'b0;
            copy_q      <= 1'b0;
            hold_data_q <= '0;
            col_q       <= '0;
        end else if (load) begin
            hold_vld_q  <= 1'b1;
            copy_q      <= 1'b0;
            hold_data_q <= load_data;
            col_q       <= col_wrap ? '0 : col_q + CW'(1);
        end else if (fwd_hs) begin
            if (copy_q) begin
                hold_vld_q <= 1'b0;
            end
            copy_q <= ~copy_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_col_q <= '0;
            out_row_q <= '0;
        end else if (fwd_hs && copy_q) begin
            if (out_col_q == COL_LAST) begin
                out_col_q <= '0;
                out_row_q <= (out_row_q == ROW_LAST) ? '0 : out_row_q + RW'(1);
            end else begin
                out_col_q <= out_col_q + CW'(1);
            end
        end
    end

    assign fwd_pxl_vld_o  = hold_vld_q;
    assign fwd_pxl_data_o = hold_data_q;
    assign fwd_pxl_last_o = hold_vld_q & copy_q &
                            (out_col_q == COL_LAST) & (out_row_q == ROW_LAST);

`ifdef DRC_UPSCALER_CHK_EN
    localparam int IRW = (IR > 1) ? $clog2(IR) : 1;
    localparam logic [IRW-1:0] IN_ROW_LAST = IRW'(IR - 1);

    logic [IRW-1:0] in_row_q;
    logic           at_end;

    assign at_end = (in_row_q == IN_ROW_LAST) & col_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_row_q  <= '0;
            frm_err_o <= 1'b0;
        end else if (load_even) begin
            if (col_wrap) begin
                in_row_q <= (in_row_q == IN_ROW_LAST) ? '0 : in_row_q + IRW'(1);
            end
            if (bwd_pxl_last_i != at_end) begin
                frm_err_o <= 1'b1;
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = bwd_pxl_last_i;
`endif

endmodule

// File: tb/tb_drc_frm_upscaler.sv
// -----------------------------------------------------------------------------
// tb_drc_frm_upscaler
//
// Directed bench for drc_frm_upscaler at 4x4 output (2x2 input frame).
// Output pixels are collected into a queue and compared against hand-written
// replication tables; ready, stall stability and frame-length error are
// checked along the way.
// -----------------------------------------------------------------------------
module tb_drc_frm_upscaler;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int R  = 4;
    localparam int NF = C * R;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] bwd_pxl_data_i = '0;
    logic         bwd_pxl_last_i = 1'b0;
    logic         bwd_pxl_vld_i = 1'b0;
    logic         bwd_pxl_rdy_o;
    logic [W-1:0] fwd_pxl_data_o;
    logic         fwd_pxl_last_o;
    logic         fwd_pxl_vld_o;
    logic         fwd_pxl_rdy_i = 1'b0;
`ifdef DRC_UPSCALER_CHK_EN
    logic         frm_err_o;
`endif

    drc_frm_upscaler #(
        .I_PXL_W (W),
        .COL_NUM (C),
        .ROW_NUM (R)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bwd_pxl_data_i (bwd_pxl_data_i),
        .bwd_pxl_last_i (bwd_pxl_last_i),
        .bwd_pxl_vld_i  (bwd_pxl_vld_i),
        .bwd_pxl_rdy_o  (bwd_pxl_rdy_o),
        .fwd_pxl_data_o (fwd_pxl_data_o),
        .fwd_pxl_last_o (fwd_pxl_last_o),
        .fwd_pxl_vld_o  (fwd_pxl_vld_o),
        .fwd_pxl_rdy_i  (fwd_pxl_rdy_i)
`ifdef DRC_UPSCALER_CHK_EN
        ,
        .frm_err_o      (frm_err_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------ input side
    logic [W-1:0] in_d [$];
    logic         in_l [$];
    logic         hs_seen = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            hs_seen = rst_n && bwd_pxl_vld_i && bwd_pxl_rdy_o;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (hs_seen && in_d.size() > 0) begin
                void'(in_d.pop_front());
                void'(in_l.pop_front());
            end
            #1;
            if (in_d.size() > 0) begin
                bwd_pxl_vld_i  = 1'b1;
                bwd_pxl_data_i = in_d[0];
                bwd_pxl_last_i = in_l[0];
            end else begin
                bwd_pxl_vld_i  = 1'b0;
                bwd_pxl_last_i = 1'b0;
            end
        end
    end

    // 0: always ready, 1: toggle every cycle
    int rdy_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            fwd_pxl_rdy_i = (rdy_mode == 0) ? 1'b1 : ~fwd_pxl_rdy_i;
        end
    end

    // ----------------------------------------------------------- output side
    logic [W-1:0] out_d [$];
    logic         out_l [$];
    logic         chk_rdy_en = 1'b0;
    int           cyc = 0;
    int           first_cyc = 0;
    int           last_cyc = 0;

    initial begin
        logic         stall_q;
        logic [W-1:0] stall_d;
        logic         exp_rdy;
        int           i, r, c;
        stall_q = 1'b0;
        stall_d = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (stall_q) begin
                    chk("stall_vld", 32'(fwd_pxl_vld_o), 32'd1);
                    chk("stall_data", 32'(fwd_pxl_data_o), 32'(stall_d));
                end
                stall_q = fwd_pxl_vld_o && !fwd_pxl_rdy_i;
                stall_d = fwd_pxl_data_o;
                if (fwd_pxl_vld_o && chk_rdy_en) begin
                    // Input is taken only while the second replica of an
                    // even-row pixel leaves, except for the row's last pixel
                    // (replay follows), plus the odd row's final replica.
                    i = out_d.size() % NF;
                    r = i / C;
                    c = i % C;
                    exp_rdy = fwd_pxl_rdy_i && (c % 2 == 1) &&
                              (((r % 2 == 0) && (c != C - 1)) ||
                               ((r % 2 == 1) && (c == C - 1)));
                    chk($sformatf("bwd_rdy_%0d", i), 32'(bwd_pxl_rdy_o), 32'(exp_rdy));
                end
                if (fwd_pxl_vld_o && fwd_pxl_rdy_i) begin
                    if (out_d.size() == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    out_d.push_back(fwd_pxl_data_o);
                    out_l.push_back(fwd_pxl_last_o);
                end
            end else begin
                stall_q = 1'b0;
            end
        end
    end

    // --------------------------------------------------------------- helpers
    task automatic push_frame(input logic [31:0] word, input int last_idx);
        for (int k = 0; k < 4; k++) begin
            in_d.push_back(word[(3-k)*8 +: 8]);
            in_l.push_back(k == last_idx);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_d.delete();
        in_l.delete();
        bwd_pxl_vld_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        out_d.delete();
        out_l.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_outs(input int n, input string tag);
        int t;
        t = 0;
        while (out_d.size() < n && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk({tag, "_count"}, 32'(out_d.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int base, input logic [31:0] word);
        int seq [16];
        int k;
        seq = '{0, 0, 1, 1, 0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 3, 3};
        if (out_d.size() >= base + NF) begin
            for (int i = 0; i < NF; i++) begin
                k = seq[i];
                chk($sformatf("%s_data%0d", tag, i), 32'(out_d[base+i]), 32'(word[(3-k)*8 +: 8]));
                chk($sformatf("%s_last%0d", tag, i), 32'(out_l[base+i]), (i == NF - 1) ? 32'd1 : 32'd0);
            end
        end
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        // reset state
        @(negedge clk);
        chk("rst_fwd_vld", 32'(fwd_pxl_vld_o), 32'd0);
        chk("rst_fwd_data", 32'(fwd_pxl_data_o), 32'd0);
        chk("rst_fwd_last", 32'(fwd_pxl_last_o), 32'd0);
        chk("rst_bwd_rdy", 32'(bwd_pxl_rdy_o), 32'd1);
`ifdef DRC_UPSCALER_CHK_EN
        chk("rst_err", 32'(frm_err_o), 32'd0);
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // A,B,C,D with output always ready
        rdy_mode   = 0;
        chk_rdy_en = 1'b1;
        push_frame(32'h11223344, 3);
        wait_outs(NF, "basic");
        check_frame("basic", 0, 32'h11223344);

        // output ready toggling every cycle
        do_reset();
        rdy_mode = 1;
        push_frame(32'h55667788, 3);
        wait_outs(NF, "toggle");
        check_frame("toggle", 0, 32'h55667788);

        // two back-to-back frames, no bubbles
        do_reset();
        rdy_mode = 0;
        push_frame(32'hA1B2C3D4, 3);
        push_frame(32'h0F1E2D3C, 3);
        wait_outs(2 * NF, "b2b");
        check_frame("b2b_f0", 0, 32'hA1B2C3D4);
        check_frame("b2b_f1", NF, 32'h0F1E2D3C);
        chk("b2b_no_bubble", 32'(last_cyc - first_cyc), 32'(2 * NF - 1));
        chk_rdy_en = 1'b0;

        // reset after five outputs discards the partial frame
        do_reset();
        push_frame(32'h11223344, 3);
        wait_outs(5, "midrst");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_d.delete();
        in_l.delete();
        bwd_pxl_vld_i = 1'b0;
        @(posedge clk);
        #2;
        out_d.delete();
        out_l.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_vld", 32'(fwd_pxl_vld_o), 32'd0);
        chk("midrst_rdy", 32'(bwd_pxl_rdy_o), 32'd1);
        push_frame(32'hE1E2E3E4, 3);
        wait_outs(NF, "midrst_new");
        check_frame("midrst_new", 0, 32'hE1E2E3E4);

        // early last on the second input pixel
        do_reset();
        push_frame(32'h9A8B7C6D, 1);
`ifdef DRC_UPSCALER_CHK_EN
        @(negedge clk);
        chk("err_before", 32'(frm_err_o), 32'd0);
        begin
            int t;
            t = 0;
            while (in_d.size() > 2 && t < 100) begin
                @(posedge clk);
                #2;
                t++;
            end
        end
        @(negedge clk);
        chk("err_set", 32'(frm_err_o), 32'd1);
`endif
        wait_outs(NF, "errlast");
        check_frame("errlast", 0, 32'h9A8B7C6D);
`ifdef DRC_UPSCALER_CHK_EN
        chk("err_held", 32'(frm_err_o), 32'd1);
        do_reset();
        @(negedge clk);
        chk("err_cleared", 32'(frm_err_o), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/drc_frm_upscaler.md
DRC_FRM_UPSCALER -- requirements
Module: drc_frm_upscaler

Interface
REQ-001 Parameter DOWNSCALE-inverse: I_PXL_W, default 8, pixel width in bits.
REQ-002 Parameter COL_NUM, default 640, output columns per row; even, >= 4.
REQ-003 Parameter ROW_NUM, default 480, output rows per frame; even, >= 2.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 bwd_pxl_data_i  input  I_PXL_W  input pixel (frame of COL_NUM/2 x ROW_NUM/2).
REQ-007 bwd_pxl_last_i  input  1  last input pixel of frame.
REQ-008 bwd_pxl_vld_i  input  1  input pixel valid.
REQ-009 bwd_pxl_rdy_o  output  1  input ready.
REQ-010 fwd_pxl_data_o  output  I_PXL_W  output pixel (COL_NUM x ROW_NUM frame).
REQ-011 fwd_pxl_last_o  output  1  last output pixel of frame.
REQ-012 fwd_pxl_vld_o  output  1  output valid.
REQ-013 fwd_pxl_rdy_i  input  1  output ready.
REQ-014 frm_err_o  output  1  sticky frame-length error; present only with DRC_UPSCALER_CHK_EN.

Function
REQ-015 Upscaling SHALL be 2x2 nearest-neighbour: input pixel (r,c) drives output pixels (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
REQ-016 Handshake on each side SHALL occur when vld & rdy are high on a rising edge; vld, data, last SHALL stay stable while vld=1 and rdy=0.
REQ-017 FSM states: ROW_EVEN (consume input, emit, store to line buffer), ROW_ODD (replay line buffer, no input consumed).
REQ-018 Line buffer SHALL be COL_NUM/2 x I_PXL_W register array, combinational read, written at in_col index on each input handshake in ROW_EVEN.
REQ-019 Output hold register (data, copy bit) SHALL drive fwd_pxl_*; copy=0 emits first replica, copy=1 second; hold empties on handshake with copy=1.
REQ-020 ROW_EVEN: bwd_pxl_rdy_o = hold empty OR (copy=1 AND fwd handshake this cycle); combinational path fwd_pxl_rdy_i -> bwd_pxl_rdy_o permitted.
REQ-021 Latency: accepted input pixel SHALL appear on fwd_pxl_data_o the next cycle; sustained throughput 1 output pixel/cycle with no bubbles when fwd_pxl_rdy_i=1.
REQ-022 ROW_ODD: bwd_pxl_rdy_o SHALL be 0; hold reloads from line buffer at rd index under the same refill rule as REQ-020.
REQ-023 Column counter (0..COL_NUM/2-1) wraps to 0 after final column; wrap of the final load in ROW_EVEN -> ROW_ODD, final load in ROW_ODD -> ROW_EVEN.
REQ-024 Output row counter (0..ROW_NUM-1) SHALL advance on second-replica handshake of last column; wraps to 0 after ROW_NUM-1.
REQ-025 fwd_pxl_last_o SHALL be 1 only on output pixel (ROW_NUM-1, COL_NUM-1), derived from counters, not from bwd_pxl_last_i.
REQ-026 Line buffer overwrite in ROW_EVEN SHALL not corrupt pending ROW_ODD data (ROW_ODD completes before any next-row write).

Reset
REQ-027 On rst_n=0: FSM=ROW_EVEN, counters=0, hold empty, copy=0; fwd_pxl_vld_o=0, fwd_pxl_data_o=0, fwd_pxl_last_o=0, bwd_pxl_rdy_o=1, frm_err_o=0.
REQ-028 Reset mid-frame SHALL discard partial frame; line buffer contents need not be cleared.

Configuration
REQ-029 Macro DRC_UPSCALER_CHK_EN defined: frm_err_o sets when bwd_pxl_last_i=1 on a handshake not at input (ROW_NUM/2-1, COL_NUM/2-1), or =0 at that position; clears only on reset.
REQ-030 Macro undefined: frm_err_o port and check logic absent; bwd_pxl_last_i ignored.

Verification (COL_NUM=4, ROW_NUM=4 unless stated)
REQ-031 Inputs A,B,C,D, fwd_rdy=1 -> output A,A,B,B,A,A,B,B,C,C,D,D,C,C,D,D; last only on 16th.
REQ-032 fwd_rdy toggled 1/0 every cycle -> same sequence, outputs stable while stalled, bwd_rdy=0 during ROW_ODD.
REQ-033 Two back-to-back frames, vld=1 continuous -> no bubble when fwd_rdy=1, row counter wraps, last on 16th and 32nd pixel.
REQ-034 rst_n pulsed after 5 outputs -> vld=0, rdy=1 next cycle; next frame starting with E emits E,E first.
REQ-035 CHK_EN: bwd_last=1 on input B -> frm_err_o=1 cycle after, held until reset; without macro, no effect.
REQ-036 Default 640x480, random data and backpressure -> scoreboard matches reference 2x replication over 3 frames.
